id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus EX-stage operand selection, directly upstream of the ALU.

---
 rtl/id_ex_operand_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Feeds ALU operands, ALU control and store data for the instruction currently in EX.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [3:0]        id_alu_ctr,
    input  logic              id_alu_src,
    input  logic              id_shift,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              load_use_stall,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctr,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]        ex_shamt;
    logic [REG_W-1:0]  ex_rs, ex_rt;
    logic              ex_alu_src, ex_shift;
    logic              reg_write_q, mem_read_q, mem_write_q;

    logic uses_rs, uses_rt, hazard, load_bubble;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    assign uses_rt = ~id_alu_src | id_mem_write;
    assign uses_rs = ~id_shift;

    assign hazard = ex_valid & mem_read_q & (ex_rd != '0) & id_valid &
                    ((uses_rs & (ex_rd == id_rs)) | (uses_rt & (ex_rd == id_rt)));

    assign load_use_stall = hazard & ~flush;
    assign load_bubble    = flush | hazard | ~id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_shamt    <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            alu_ctr     <= '0;
            ex_alu_src  <= 1'b0;
            ex_shift    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            ex_shamt    <= id_shamt;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            alu_ctr     <= id_alu_ctr;
            ex_alu_src  <= id_alu_src;
            ex_shift    <= id_shift;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
            mem_write_q <= id_mem_write;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; r0 never forwards.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rs)
            fwd_rs = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rs)
            fwd_rs = memwb_result;
    end

    always_comb begin
        fwd_rt = ex_rt_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rt)
            fwd_rt = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rt)
            fwd_rt = memwb_result;
    end

    assign alu_a         = ex_shift ? {{(DATA_W-5){1'b0}}, ex_shamt} : fwd_rs;
    assign alu_b         = ex_alu_src ? ex_imm : fwd_rt;
    assign ex_store_data = fwd_rt;

    assign ex_reg_write = reg_write_q & ex_valid;
    assign ex_mem_read  = mem_read_q & ex_valid;
    assign ex_mem_write = mem_write_q & ex_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table for forwarding/operand select,
// hand-written sequences for reset, load-use stall and flush.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_shamt = '0, id_rs = '0, id_rt = '0, id_rd = '0;
    logic [3:0]  id_alu_ctr = '0;
    logic        id_alu_src = 1'b0, id_shift = 1'b0, id_reg_write = 1'b0;
    logic        id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
    logic [4:0]  exmem_rd = '0, memwb_rd = '0;
    logic [31:0] exmem_result = '0, memwb_result = '0;

    logic        load_use_stall;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [3:0]  alu_ctr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_operand_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_ctr(id_alu_ctr), .id_alu_src(id_alu_src), .id_shift(id_shift),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] rs_data, rt_data, imm;
        logic [3:0]  ctr;
        logic        alu_src, shift, reg_write, mem_write;
        logic        xm_we;
        logic [4:0]  xm_rd;
        logic [31:0] xm_res;
        logic        mw_we;
        logic [4:0]  mw_rd;
        logic [31:0] mw_res;
        logic [31:0] exp_a, exp_b, exp_store;
        logic        exp_valid;
        logic [3:0]  exp_ctr;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rs_d, input logic [31:0] rt_d,
                            input logic [31:0] imm, input logic [3:0] ctr, input logic src,
                            input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rs_d; id_rt_data = rt_d;
        id_imm = imm; id_alu_ctr = ctr; id_alu_src = src; id_shift = 1'b0; id_shamt = '0;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_pc = 32'h100;
    endtask

    initial begin
        //        valid rs rt rd sh  rs_data       rt_data       imm           ctr src shf rw mw  xm_we xm_rd xm_res         mw_we mw_rd mw_res        exp_a          exp_b          exp_store     exv ctr rw
        vecs[0] = '{1'b1, 5'd3, 5'd2, 5'd8, 5'd0, 32'h7,     32'h5,     32'h0,  4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h15,       1'b0, 5'd0, 32'h0,   32'h15,   32'h5,    32'h5,    1'b1, 4'd2, 1'b1};
        vecs[1] = '{1'b1, 5'd1, 5'd5, 5'd9, 5'd0, 32'h10,    32'h99,    32'h0,  4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hAAAA,     1'b1, 5'd5, 32'hBBBB, 32'h10,  32'hAAAA, 32'hAAAA, 1'b1, 4'd6, 1'b1};
        vecs[2] = '{1'b1, 5'd6, 5'd7, 5'd10, 5'd0, 32'h1,    32'h2,     32'h0,  4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h999,      1'b1, 5'd6, 32'h5A,  32'h5A,   32'h2,    32'h2,    1'b1, 4'd1, 1'b1};
        vecs[3] = '{1'b1, 5'd0, 5'd0, 5'd11, 5'd0, 32'h0,    32'h0,     32'h40, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h33,  32'h0,    32'h40,   32'h0,    1'b1, 4'd2, 1'b1};
        vecs[4] = '{1'b1, 5'd0, 5'd8, 5'd12, 5'd4, 32'h0,    32'h1,     32'h0,  4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   32'h4,    32'h1,    32'h1,    1'b1, 4'd3, 1'b1};
        vecs[5] = '{1'b1, 5'd2, 5'd9, 5'd0, 5'd0, 32'h100,   32'h11,    32'h8,  4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h77,       1'b1, 5'd2, 32'h200, 32'h200,  32'h8,    32'h77,   1'b1, 4'd2, 1'b0};
        vecs[6] = '{1'b1, 5'd4, 5'd3, 5'd13, 5'd0, 32'h44,   32'h30,    32'h0,  4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'hDEAD,     1'b1, 5'd4, 32'hBEEF, 32'hBEEF, 32'h30,  32'h30,   1'b1, 4'd7, 1'b1};
        vecs[7] = '{1'b0, 5'd3, 5'd3, 5'd14, 5'd0, 32'h55,   32'h66,    32'h0,  4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h123,      1'b0, 5'd0, 32'h0,   32'h0,    32'h0,    32'h0,    1'b0, 4'd0, 1'b0};

        // Reset state
        #12;
        chk("reset ex_valid", 32'(ex_valid), 32'h0);
        chk("reset alu_ctr", 32'(alu_ctr), 32'h0);
        chk("reset alu_a", alu_a, 32'h0);
        chk("reset alu_b", alu_b, 32'h0);
        chk("reset store_data", ex_store_data, 32'h0);
        chk("reset stall", 32'(load_use_stall), 32'h0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            clear_fwd();
            id_valid = vecs[i].valid; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
            id_shamt = vecs[i].shamt; id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data;
            id_imm = vecs[i].imm; id_alu_ctr = vecs[i].ctr; id_alu_src = vecs[i].alu_src;
            id_shift = vecs[i].shift; id_reg_write = vecs[i].reg_write; id_mem_read = 1'b0;
            id_mem_write = vecs[i].mem_write; id_pc = 32'h400 + 32'(i * 4);
            @(posedge clk); #1;
            exmem_reg_write = vecs[i].xm_we; exmem_rd = vecs[i].xm_rd; exmem_result = vecs[i].xm_res;
            memwb_reg_write = vecs[i].mw_we; memwb_rd = vecs[i].mw_rd; memwb_result = vecs[i].mw_res;
            #1;
            chk($sformatf("v%0d alu_a", i), alu_a, vecs[i].exp_a);
            chk($sformatf("v%0d alu_b", i), alu_b, vecs[i].exp_b);
            chk($sformatf("v%0d store", i), ex_store_data, vecs[i].exp_store);
            chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d alu_ctr", i), 32'(alu_ctr), 32'(vecs[i].exp_ctr));
            chk($sformatf("v%0d ex_reg_write", i), 32'(ex_reg_write), 32'(vecs[i].exp_rw));
            if (vecs[i].exp_valid)
                chk($sformatf("v%0d ex_pc", i), ex_pc, 32'h400 + 32'(i * 4));
        end

        // Reset mid-stream
        clear_fwd();
        drive_id(1'b1, 5'd3, 5'd2, 5'd8, 32'h7, 32'h5, 32'h0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("midrst pre ex_valid", 32'(ex_valid), 32'h1);
        chk("midrst pre alu_ctr", 32'(alu_ctr), 32'h6);
        #3 rst = 1'b1; #1;
        chk("midrst ex_valid", 32'(ex_valid), 32'h0);
        chk("midrst alu_ctr", 32'(alu_ctr), 32'h0);
        chk("midrst alu_a", alu_a, 32'h0);
        chk("midrst alu_b", alu_b, 32'h0);
        chk("midrst stall", 32'(load_use_stall), 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst load ex_valid", 32'(ex_valid), 32'h1);

        // Load-use: lw r4 then add r6,r4,r2
        clear_fwd();
        drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 32'h0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive_id(1'b1, 5'd4, 5'd2, 5'd6, 32'hDEAD, 32'h22, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu ex_mem_read", 32'(ex_mem_read), 32'h1);
        chk("lu stall", 32'(load_use_stall), 32'h1);
        @(posedge clk); #1;
        chk("lu bubble ex_valid", 32'(ex_valid), 32'h0);
        chk("lu stall cleared", 32'(load_use_stall), 32'h0);
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h1234;
        @(posedge clk); #1;
        chk("lu add ex_valid", 32'(ex_valid), 32'h1);
        chk("lu add alu_a", alu_a, 32'h1234);
        chk("lu add alu_b", alu_b, 32'h22);

        // Load followed by an immediate op that only reads rt-as-destination: no stall
        clear_fwd();
        drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 32'h0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive_id(1'b1, 5'd5, 5'd4, 5'd4, 32'h0, 32'h0, 32'h3, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu no-use stall", 32'(load_use_stall), 32'h0);

        // Load-use coincident with flush: flush wins, bubble enters EX
        drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 32'h0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive_id(1'b1, 5'd7, 5'd4, 5'd0, 32'h0, 32'h9, 32'h4, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush stall", 32'(load_use_stall), 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush ex_valid", 32'(ex_valid), 32'h0);
        chk("flush ex_reg_write", 32'(ex_reg_write), 32'h0);
        chk("flush ex_mem_write", 32'(ex_mem_write), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
